peripheral_pwm_n: RTL and testbench

PERIPHERAL_PWM_N -- requirements
Module: peripheral_pwm_n

---
 rtl/peripheral_pwm_n_if.sv | 15 +
 rtl/peripheral_pwm_n.sv | 136 +++++++++++++
 tb/tb_peripheral_pwm_n.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_pwm_n_if.sv
// Register bus between a host and peripheral_pwm_n: chip select, read/write
// strobes, byte address, write data and registered read data.
interface peripheral_pwm_n_if #(
    parameter int AW = 8
);
    logic          cs;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   d_in;
    logic [31:0]   d_out;

    modport master (output cs, rd, wr, addr, d_in, input d_out);
    modport slave  (input cs, rd, wr, addr, d_in, output d_out);
endinterface

// File: rtl/peripheral_pwm_n.sv
// NCH independent PWM channels with CTRL/PERIOD/DUTY/COUNT registers per channel.
// Define PWM_SHADOW_EN to buffer PERIOD/DUTY writes until the next counter wrap.
module peripheral_pwm_n #(
    parameter int NCH = 8,
    parameter int CW  = 16,
    parameter int AW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    peripheral_pwm_n_if.slave  bus,
    output logic [NCH-1:0]     pwm
);
    localparam int IW = AW - 4;

    logic [IW-1:0]  ch_s;
    logic [3:0]     off_s;
    logic           wr_en_s;
    logic           rd_en_s;
    logic           unused_bits_s;

    logic [NCH-1:0] en_r;
    logic [NCH-1:0] pol_r;
    logic [NCH-1:0] pwm_r;
    logic [CW-1:0]  period_r [NCH];
    logic [CW-1:0]  duty_r   [NCH];
    logic [CW-1:0]  count_r  [NCH];
`ifdef PWM_SHADOW_EN
    logic [CW-1:0]  period_sh_r [NCH];
    logic [CW-1:0]  duty_sh_r   [NCH];
`endif

    logic [NCH-1:0] sel_s;
    logic [NCH-1:0] wrap_s;
    logic [NCH-1:0] raw_s;
    logic [31:0]    ch_word_s [NCH];
    logic [31:0]    rd_data_s;
    logic [31:0]    d_out_r;

    assign ch_s          = bus.addr[AW-1:4];
    assign off_s         = bus.addr[3:0];
    assign wr_en_s       = bus.cs && bus.wr;
    assign rd_en_s       = bus.cs && bus.rd;
    assign unused_bits_s = ^bus.d_in;
    assign pwm           = pwm_r;
    assign bus.d_out     = d_out_r;

    // Per-channel address match, wrap/duty compare and readable register word.
    // Index values >= NCH match no channel, so they read 0 and drop writes.
    always_comb begin
        sel_s  = {NCH{1'b0}};
        wrap_s = {NCH{1'b0}};
        raw_s  = {NCH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            sel_s[k]  = (ch_s == IW'(k));
            wrap_s[k] = en_r[k] && (count_r[k] >= period_r[k]);
            raw_s[k]  = en_r[k] && (count_r[k] < duty_r[k]);
            case (off_s)
                4'h0:    ch_word_s[k] = {30'h0000_0000, pol_r[k], en_r[k]};
`ifdef PWM_SHADOW_EN
                4'h4:    ch_word_s[k] = 32'(period_sh_r[k]);
                4'h8:    ch_word_s[k] = 32'(duty_sh_r[k]);
`else
                4'h4:    ch_word_s[k] = 32'(period_r[k]);
                4'h8:    ch_word_s[k] = 32'(duty_r[k]);
`endif
                4'hC:    ch_word_s[k] = 32'(count_r[k]);
                default: ch_word_s[k] = 32'h0000_0000;
            endcase
        end
    end

    // Read data mux: at most one channel matches, so OR-reduce the masked words.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        for (int k = 0; k < NCH; k++) begin
            rd_data_s = rd_data_s | (sel_s[k] ? ch_word_s[k] : 32'h0000_0000);
        end
    end

    // Registered read port; idle cycles return 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out_r <= 32'h0000_0000;
        end else begin
            d_out_r <= rd_en_s ? rd_data_s : 32'h0000_0000;
        end
    end

    // Channel registers, counters and registered PWM outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_r  <= {NCH{1'b0}};
            pol_r <= {NCH{1'b0}};
            pwm_r <= {NCH{1'b0}};
            for (int k = 0; k < NCH; k++) begin
                period_r[k] <= {CW{1'b0}};
                duty_r[k]   <= {CW{1'b0}};
                count_r[k]  <= {CW{1'b0}};
`ifdef PWM_SHADOW_EN
                period_sh_r[k] <= {CW{1'b0}};
                duty_sh_r[k]   <= {CW{1'b0}};
`endif
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (wr_en_s && sel_s[k] && (off_s == 4'h0)) begin
                    en_r[k]  <= bus.d_in[0];
                    pol_r[k] <= bus.d_in[1];
                end
`ifdef PWM_SHADOW_EN
                // Active values follow the shadows while idle or at a wrap.
                if (!en_r[k] || wrap_s[k]) begin
                    period_r[k] <= period_sh_r[k];
                    duty_r[k]   <= duty_sh_r[k];
                end
                if (wr_en_s && sel_s[k] && (off_s == 4'h4)) begin
                    period_sh_r[k] <= bus.d_in[CW-1:0];
                end
                if (wr_en_s && sel_s[k] && (off_s == 4'h8)) begin
                    duty_sh_r[k] <= bus.d_in[CW-1:0];
                end
`else
                if (wr_en_s && sel_s[k] && (off_s == 4'h4)) begin
                    period_r[k] <= bus.d_in[CW-1:0];
                end
                if (wr_en_s && sel_s[k] && (off_s == 4'h8)) begin
                    duty_r[k] <= bus.d_in[CW-1:0];
                end
`endif
                count_r[k] <= (!en_r[k] || wrap_s[k]) ? {CW{1'b0}}
                                                      : count_r[k] + {{(CW-1){1'b0}}, 1'b1};
                pwm_r[k]   <= raw_s[k] ^ pol_r[k];
            end
        end
    end
endmodule

// File: tb/tb_peripheral_pwm_n.sv
// Randomized bench for peripheral_pwm_n against a cycle-level behavioural model
// of the register map and PWM rules, plus directed scenario checks.
module tb_peripheral_pwm_n;
    localparam int NCH = 8;
    localparam int CW  = 16;
    localparam int AW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] pwm;
    int             total;
    int             bad;

    peripheral_pwm_n_if #(.AW(AW)) bus ();

    peripheral_pwm_n #(.NCH(NCH), .CW(CW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .pwm (pwm)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic           m_en    [NCH];
    logic           m_pol   [NCH];
    logic [15:0]    m_per   [NCH];
    logic [15:0]    m_duty  [NCH];
    logic [15:0]    m_sper  [NCH];
    logic [15:0]    m_sduty [NCH];
    logic [15:0]    m_cnt   [NCH];
    logic [NCH-1:0] exp_pwm;
    logic [31:0]    exp_dout;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int ch;
        ch = int'(a[7:4]);
        if (ch >= NCH) return 32'h0;
        case (a[3:0])
            4'h0: return {30'h0, m_pol[ch], m_en[ch]};
`ifdef PWM_SHADOW_EN
            4'h4: return {16'h0, m_sper[ch]};
            4'h8: return {16'h0, m_sduty[ch]};
`else
            4'h4: return {16'h0, m_per[ch]};
            4'h8: return {16'h0, m_duty[ch]};
`endif
            4'hC: return {16'h0, m_cnt[ch]};
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs presented to it.
    task automatic model_step();
        logic wrap;
        int   ch;
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                m_en[k] = 1'b0; m_pol[k] = 1'b0; m_per[k] = 16'h0; m_duty[k] = 16'h0;
                m_sper[k] = 16'h0; m_sduty[k] = 16'h0; m_cnt[k] = 16'h0;
            end
            exp_pwm  = '0;
            exp_dout = 32'h0;
        end else begin
            exp_dout = (bus.cs && bus.rd) ? m_read(bus.addr) : 32'h0;
            for (int k = 0; k < NCH; k++) begin
                exp_pwm[k] = (m_en[k] && (m_cnt[k] < m_duty[k])) ^ m_pol[k];
                wrap = m_en[k] && (m_cnt[k] >= m_per[k]);
                m_cnt[k] = (m_en[k] && !wrap) ? m_cnt[k] + 16'd1 : 16'd0;
`ifdef PWM_SHADOW_EN
                if (!m_en[k] || wrap) begin
                    m_per[k]  = m_sper[k];
                    m_duty[k] = m_sduty[k];
                end
`endif
            end
            ch = int'(bus.addr[7:4]);
            if (bus.cs && bus.wr && ch < NCH) begin
                case (bus.addr[3:0])
                    4'h0: begin m_en[ch] = bus.d_in[0]; m_pol[ch] = bus.d_in[1]; end
`ifdef PWM_SHADOW_EN
                    4'h4: m_sper[ch]  = bus.d_in[15:0];
                    4'h8: m_sduty[ch] = bus.d_in[15:0];
`else
                    4'h4: m_per[ch]   = bus.d_in[15:0];
                    4'h8: m_duty[ch]  = bus.d_in[15:0];
`endif
                    default: ;
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_val("pwm", 32'(pwm), 32'(exp_pwm));
        check_val("d_out", bus.d_out, exp_dout);
    endtask

    task automatic idle();
        bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic wr_reg(input int ch, input int off, input logic [31:0] data);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0;
        bus.addr = 8'((ch << 4) | off);
        bus.d_in = data;
        tick();
        idle();
    endtask

    task automatic rd_reg(input int ch, input int off, output logic [31:0] data);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0;
        bus.addr = 8'((ch << 4) | off);
        tick();
        data = bus.d_out;
        idle();
    endtask

    initial begin
        logic [31:0] rv;
        logic [31:0] expc;
        logic [31:0] dv;
        logic        exp_b;
        int          hi;
        int          found;
        int          ch;
        int          pick;

        total = 0; bad = 0;
        rst = 1'b1;
        idle();
        bus.addr = 8'h00; bus.d_in = 32'h0;
        tick(); tick();
        check_val("rst_pwm", 32'(pwm), 32'h0);
        check_val("rst_dout", bus.d_out, 32'h0);
        rst = 1'b0;

        // ch0: PERIOD=9 DUTY=3 -> 3 high cycles in every 10
        wr_reg(0, 4, 32'd9); wr_reg(0, 8, 32'd3); wr_reg(0, 0, 32'd1);
        tick(); tick();
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pwm[0]) hi++;
        end
        check_val("ch0_high_cycles", 32'(hi), 32'd3);

        // ch2: inverted polarity, disabled, then zero duty
        wr_reg(2, 0, 32'd2);
        tick();
        check_val("ch2_pol_idle", 32'(pwm[2]), 32'd1);
        wr_reg(2, 8, 32'd0); wr_reg(2, 4, 32'd4); wr_reg(2, 0, 32'd3);
        for (int i = 0; i < 12; i++) begin
            tick();
            check_val("ch2_duty0", 32'(pwm[2]), 32'd1);
        end

        // ch1: mid-period duty change
        wr_reg(1, 4, 32'd7); wr_reg(1, 8, 32'd2); wr_reg(1, 0, 32'd1);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            tick();
            if (m_cnt[1] == 16'd3) found = 1;
        end
        check_val("ch1_sync", 32'(found), 32'd1);
        wr_reg(1, 8, 32'd6);
        tick();
`ifdef PWM_SHADOW_EN
        exp_b = 1'b0;
`else
        exp_b = 1'b1;
`endif
        check_val("ch1_new_duty", 32'(pwm[1]), 32'(exp_b));
        for (int i = 0; i < 20; i++) tick();

        // Readback, live count, out-of-range channels
        wr_reg(3, 8, 32'h0000_1234);
        rd_reg(3, 8, rv);
        check_val("ch3_duty_rd", rv, 32'h0000_1234);
        expc = {16'h0, m_cnt[1]};
        rd_reg(1, 12, rv);
        check_val("ch1_count_rd", rv, expc);
        rd_reg(9, 8, rv);
        check_val("ch9_rd", rv, 32'h0);
        rd_reg(15, 0, rv);
        check_val("ch15_rd", rv, 32'h0);
        wr_reg(9, 8, 32'h55);
        rd_reg(1, 1, rv);
        check_val("unmapped_rd", rv, 32'h0);

        // Reset mid-period while ch0 runs, overlapping a bus write
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        wr_reg(0, 4, 32'd5);
        rst = 1'b0;
        check_val("rst2_pwm", 32'(pwm), 32'h0);
        check_val("rst2_dout", bus.d_out, 32'h0);
        for (int off = 0; off < 16; off += 4) begin
            rd_reg(0, off, rv);
            check_val("rst2_ch0_reg", rv, 32'h0);
        end
        rd_reg(3, 8, rv);
        check_val("rst2_ch3_duty", rv, 32'h0);

        // Randomized bus traffic against the model
        for (int i = 0; i < 800; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            bus.cs = ($urandom_range(0, 3) != 0);
            bus.rd = 1'($urandom_range(0, 1));
            bus.wr = ($urandom_range(0, 2) == 0);
            ch     = $urandom_range(0, 9);
            pick   = $urandom_range(0, 4);
            dv     = $urandom;
            if (pick == 4) begin
                bus.addr = 8'((ch << 4) | $urandom_range(0, 15));
            end else begin
                bus.addr = 8'((ch << 4) | (pick * 4));
            end
            if (pick == 1) dv[15:0] = 16'($urandom_range(0, 12));
            if (pick == 2) dv[15:0] = 16'($urandom_range(0, 14));
            if (pick == 0) dv[0] = ($urandom_range(0, 3) != 0);
            bus.d_in = dv;
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
